// File: rtl/tdc_frame_collector.sv
// tdc_frame_collector: sorts channel-tagged TDC time words into a
// NUM_GROUPS x NUM_CH working frame with per-entry valid bits. At the close of
// the last group it commits the frame into a shadow store, which software then
// reads through a registered port and releases with rd_ack.
module tdc_frame_collector #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned NUM_GROUPS = 5,
  parameter int unsigned DATA_W     = 28,
  parameter int unsigned CH_W       = 3,
  parameter int unsigned GRP_W      = 3,
  parameter int unsigned SEQ_W      = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_ch,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_group_end,
  input  logic              frame_abort,
  output logic              frame_ready,
  output logic              frame_commit,
  output logic [SEQ_W-1:0]  frame_seq,
  output logic [GRP_W-1:0]  cur_group,
  input  logic              rd_en,
  input  logic [GRP_W-1:0]  rd_group,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_entry_vld,
  input  logic              rd_ack,
  output logic              dup_err,
  output logic              drop_err,
  output logic              ovf_err
);

  localparam int unsigned LAST_GRP = NUM_GROUPS - 1;

  // Working frame being assembled
  logic [DATA_W-1:0] wdata_q [NUM_GROUPS][NUM_CH];
  logic              wvld_q  [NUM_GROUPS][NUM_CH];
  logic [GRP_W-1:0]  cur_group_q;

  // Committed frame visible to software
  logic [DATA_W-1:0] sdata_q [NUM_GROUPS][NUM_CH];
  logic              svld_q  [NUM_GROUPS][NUM_CH];

  // Status and registered outputs
  logic              frame_ready_q;
  logic              frame_commit_q;
  logic [SEQ_W-1:0]  frame_seq_q;
  logic              dup_err_q;
  logic              drop_err_q;
  logic              ovf_err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q;

  // Decoded per-cycle events
  logic              ch_in_range;
  logic              wr_ok;
  logic              drop_c;
  logic              grp_end;
  logic              commit;
  logic              hit_vld;
  logic              dup_c;
  logic              ovf_c;
  logic              wsel [NUM_GROUPS][NUM_CH];
  logic [DATA_W-1:0] rd_hit_data;
  logic              rd_hit_vld;

  // Input decode: abort masks every write, group close and error
  always_comb begin
    ch_in_range = (32'(in_ch) < NUM_CH);
    wr_ok       = in_valid && ch_in_range && !frame_abort;
    drop_c      = in_valid && !ch_in_range && !frame_abort;
    grp_end     = in_group_end && !frame_abort;
    commit      = grp_end && (cur_group_q == GRP_W'(LAST_GRP));
    hit_vld     = 1'b0;
    for (int g = 0; g < int'(NUM_GROUPS); g++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wsel[g][c] = wr_ok && (cur_group_q == GRP_W'(g)) && (in_ch == CH_W'(c));
        if (wsel[g][c]) begin
          hit_vld = wvld_q[g][c];
        end
      end
    end
    dup_c = wr_ok && hit_vld;
    // A same-cycle acknowledge absorbs the overflow condition
    ovf_c = commit && frame_ready_q && !rd_ack;
  end

  // Shadow read mux; unmatched (out-of-range) addresses and invalid entries give zero
  always_comb begin
    rd_hit_data = '0;
    rd_hit_vld  = 1'b0;
    for (int g = 0; g < int'(NUM_GROUPS); g++) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if ((rd_group == GRP_W'(g)) && (rd_ch == CH_W'(c))) begin
          rd_hit_vld  = svld_q[g][c];
          rd_hit_data = svld_q[g][c] ? sdata_q[g][c] : '0;
        end
      end
    end
  end

  // Working buffer and group pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          wdata_q[g][c] <= '0;
          wvld_q[g][c]  <= 1'b0;
        end
      end
      cur_group_q <= '0;
    end else if (frame_abort) begin
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          wvld_q[g][c] <= 1'b0;
        end
      end
      cur_group_q <= '0;
    end else begin
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (wsel[g][c]) begin
            wdata_q[g][c] <= in_data;
          end
          if (commit) begin
            wvld_q[g][c] <= 1'b0;
          end else if (wsel[g][c]) begin
            wvld_q[g][c] <= 1'b1;
          end
        end
      end
      if (commit) begin
        cur_group_q <= '0;
      end else if (grp_end) begin
        cur_group_q <= cur_group_q + GRP_W'(1);
      end
    end
  end

  // Shadow store: atomic copy at commit with the same-cycle word merged in
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          sdata_q[g][c] <= '0;
          svld_q[g][c]  <= 1'b0;
        end
      end
    end else if (commit) begin
      for (int g = 0; g < int'(NUM_GROUPS); g++) begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
          if (wsel[g][c]) begin
            sdata_q[g][c] <= in_data;
            svld_q[g][c]  <= 1'b1;
          end else begin
            sdata_q[g][c] <= wdata_q[g][c];
            svld_q[g][c]  <= wvld_q[g][c];
          end
        end
      end
    end
  end

  // Frame status, sequence counter and error pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_ready_q  <= 1'b0;
      frame_commit_q <= 1'b0;
      frame_seq_q    <= '0;
      dup_err_q      <= 1'b0;
      drop_err_q     <= 1'b0;
      ovf_err_q      <= 1'b0;
    end else begin
      if (commit) begin
        frame_ready_q <= 1'b1;
        frame_seq_q   <= frame_seq_q + SEQ_W'(1);
      end else if (rd_ack) begin
        frame_ready_q <= 1'b0;
      end
      frame_commit_q <= commit;
      dup_err_q      <= dup_c;
      drop_err_q     <= drop_c;
      ovf_err_q      <= ovf_c;
    end
  end

  // Registered read port; holds its value between requests
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else if (rd_en) begin
      rd_data_q <= rd_hit_data;
      rd_vld_q  <= rd_hit_vld;
    end
  end

  assign frame_ready  = frame_ready_q;
  assign frame_commit = frame_commit_q;
  assign frame_seq    = frame_seq_q;
  assign cur_group    = cur_group_q;
  assign rd_data      = rd_data_q;
  assign rd_entry_vld = rd_vld_q;
  assign dup_err      = dup_err_q;
  assign drop_err     = drop_err_q;
  assign ovf_err      = ovf_err_q;

endmodule

// File: tb/tb_tdc_frame_collector.sv
// Directed bench for tdc_frame_collector: one default 5x8 instance and one
// 5x6 instance sharing the same stimulus (the latter exercises dropped channels).
module tb_tdc_frame_collector;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic [2:0]  in_ch;
  logic [27:0] in_data;
  logic        in_group_end;
  logic        frame_abort;
  logic        rd_en;
  logic [2:0]  rd_group;
  logic [2:0]  rd_ch;
  logic        rd_ack;

  logic        frame_ready, frame_commit, rd_entry_vld, dup_err, drop_err, ovf_err;
  logic [7:0]  frame_seq;
  logic [2:0]  cur_group;
  logic [27:0] rd_data;

  logic        d6_frame_ready, d6_frame_commit, d6_rd_entry_vld, d6_dup_err, d6_drop_err, d6_ovf_err;
  logic [7:0]  d6_frame_seq;
  logic [2:0]  d6_cur_group;
  logic [27:0] d6_rd_data;

  int n_vec;
  int n_err;

  tdc_frame_collector u_dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_group_end(in_group_end), .frame_abort(frame_abort), .frame_ready(frame_ready),
    .frame_commit(frame_commit), .frame_seq(frame_seq), .cur_group(cur_group),
    .rd_en(rd_en), .rd_group(rd_group), .rd_ch(rd_ch), .rd_data(rd_data),
    .rd_entry_vld(rd_entry_vld), .rd_ack(rd_ack), .dup_err(dup_err),
    .drop_err(drop_err), .ovf_err(ovf_err)
  );

  tdc_frame_collector #(.NUM_CH(6)) u_dut6 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
    .in_group_end(in_group_end), .frame_abort(frame_abort), .frame_ready(d6_frame_ready),
    .frame_commit(d6_frame_commit), .frame_seq(d6_frame_seq), .cur_group(d6_cur_group),
    .rd_en(rd_en), .rd_group(rd_group), .rd_ch(rd_ch), .rd_data(d6_rd_data),
    .rd_entry_vld(d6_rd_entry_vld), .rd_ack(rd_ack), .dup_err(d6_dup_err),
    .drop_err(d6_drop_err), .ovf_err(d6_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_ch        = '0;
    in_data      = '0;
    in_group_end = 1'b0;
    frame_abort  = 1'b0;
    rd_en        = 1'b0;
    rd_ack       = 1'b0;
  endtask

  task automatic wr(input int ch, input int data, input logic gend);
    in_valid     = 1'b1;
    in_ch        = 3'(ch);
    in_data      = 28'(data);
    in_group_end = gend;
    step();
    idle();
  endtask

  task automatic gend_only(input logic ack);
    in_group_end = 1'b1;
    rd_ack       = ack;
    step();
    idle();
  endtask

  // Full 5x8 frame, data = base + 16*g + ch, group end on ch7; optional ack on the last word
  task automatic fill_frame(input int base, input logic ack_last);
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        in_valid     = 1'b1;
        in_ch        = 3'(c);
        in_data      = 28'(base + 16 * g + c);
        in_group_end = (c == 7);
        rd_ack       = ack_last && (g == 4) && (c == 7);
        step();
      end
    end
    idle();
  endtask

  task automatic rd(input int g, input int c);
    rd_en    = 1'b1;
    rd_group = 3'(g);
    rd_ch    = 3'(c);
    step();
    rd_en    = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rd_group = '0;
    rd_ch    = '0;
    idle();
    resetn = 1'b0;
    step();
    step();
    check("rst_ready", frame_ready, 0);
    check("rst_seq", frame_seq, 0);
    check("rst_group", cur_group, 0);
    check("rst_rdata", rd_data, 0);
    #2 resetn = 1'b1;
    step();

    // Full frame with cur_group tracking
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        wr(c, 16 * g + c, c == 7);
      end
      if (g == 0) check("grp_adv", cur_group, 1);
    end
    check("f1_commit", frame_commit, 1);
    check("f1_ready", frame_ready, 1);
    check("f1_seq", frame_seq, 1);
    check("f1_group", cur_group, 0);
    check("f1_ovf", ovf_err, 0);
    rd(3, 5);
    check("f1_commit_pulse", frame_commit, 0);
    check("rd35_data", rd_data, 'h35);
    check("rd35_vld", rd_entry_vld, 1);
    rd(5, 0);
    check("rd_oor_data", rd_data, 0);
    check("rd_oor_vld", rd_entry_vld, 0);
    rd(0, 1);
    rd_group = 3'd4;
    rd_ch    = 3'd4;
    step();
    check("rd_hold", rd_data, 'h01);

    // Duplicate write in group 0, sparse frame
    rd_ack = 1'b1;
    step();
    idle();
    check("ack_ready", frame_ready, 0);
    wr(2, 'h123, 1'b0);
    check("dup_first", dup_err, 0);
    wr(2, 'h456, 1'b0);
    check("dup_second", dup_err, 1);
    step();
    check("dup_pulse", dup_err, 0);
    for (int g = 0; g < 5; g++) gend_only(1'b0);
    check("f2_commit", frame_commit, 1);
    check("f2_seq", frame_seq, 2);
    check("f2_ovf", ovf_err, 0);
    rd(0, 2);
    check("rd02_data", rd_data, 'h456);
    check("rd02_vld", rd_entry_vld, 1);
    rd(0, 3);
    check("rd03_data", rd_data, 0);
    check("rd03_vld", rd_entry_vld, 0);
    rd(3, 5);
    check("rd35_stale_vld", rd_entry_vld, 0);

    // Dropped channel on the 6-channel instance
    gend_only(1'b0);
    wr(7, 'h777, 1'b0);
    check("drop_d6", d6_drop_err, 1);
    check("drop_d6_group", d6_cur_group, 1);
    check("drop_d8", drop_err, 0);
    step();
    check("drop_pulse", d6_drop_err, 0);

    // Abort with a same-cycle word and group end while in group 3
    gend_only(1'b0);
    gend_only(1'b0);
    check("pre_abort_group", cur_group, 3);
    wr(1, 'h1ff, 1'b0);
    frame_abort  = 1'b1;
    in_valid     = 1'b1;
    in_ch        = 3'd1;
    in_data      = 28'hbad;
    in_group_end = 1'b1;
    step();
    idle();
    check("abort_group", cur_group, 0);
    check("abort_dup", dup_err, 0);
    check("abort_ready", frame_ready, 1);
    check("abort_seq", frame_seq, 2);
    check("abort_commit", frame_commit, 0);
    rd(0, 2);
    check("abort_shadow", rd_data, 'h456);
    rd_ack = 1'b1;
    step();
    idle();
    fill_frame('h200, 1'b0);
    check("f3_seq", frame_seq, 3);
    check("f3_ovf", ovf_err, 0);
    rd(1, 7);
    check("rd17_data", rd_data, 'h217);
    rd(3, 1);
    check("rd31_data", rd_data, 'h231);

    // Overflow: commit again without ack
    fill_frame('h300, 1'b0);
    check("ovf_pulse", ovf_err, 1);
    check("ovf_seq", frame_seq, 4);
    check("ovf_ready", frame_ready, 1);
    rd(4, 4);
    check("ovf_shadow", rd_data, 'h344);
    check("ovf_clear", ovf_err, 0);

    // Ack coinciding with a commit: commit wins, no overflow
    fill_frame('h400, 1'b1);
    check("ackc_ovf", ovf_err, 0);
    check("ackc_ready", frame_ready, 1);
    check("ackc_seq", frame_seq, 5);
    rd_ack = 1'b1;
    step();
    idle();
    check("ack2_ready", frame_ready, 0);

    // Asynchronous reset mid-group
    fill_frame('h500, 1'b0);
    wr(0, 'h11, 1'b1);
    wr(3, 'h22, 1'b0);
    rd(0, 0);
    check("prereset_rd", rd_data, 'h500);
    #2 resetn = 1'b0;
    #1;
    check("arst_ready", frame_ready, 0);
    check("arst_seq", frame_seq, 0);
    check("arst_group", cur_group, 0);
    check("arst_rdata", rd_data, 0);
    #3 resetn = 1'b1;
    step();
    fill_frame('h600, 1'b0);
    check("post_rst_seq", frame_seq, 1);
    check("post_rst_commit", frame_commit, 1);
    rd(2, 6);
    check("post_rst_rd", rd_data, 'h626);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdc_frame_collector.md
Name: tdc_frame_collector

Overview:
Parametrised successor to the fixed 5-group × 8-channel TDC data setter. Sorts incoming channel-tagged TDC time words into a working buffer of NUM_GROUPS × NUM_CH entries, each with a valid bit. At the end of the last group it commits the frame atomically to a double-buffered shadow store. Software reads the shadow through a registered address port and acknowledges it. Adds per-entry valid mask, duplicate/drop/overflow detection, frame abort and a frame sequence counter.

Parameters:
NUM_CH, 8, channels per group (1..16)
NUM_GROUPS, 5, groups per frame (1..8)
DATA_W, 28, width of one time word
CH_W, 3, width of channel index; must satisfy 2**CH_W >= NUM_CH
GRP_W, 3, width of group index; must satisfy 2**GRP_W >= NUM_GROUPS
SEQ_W, 8, frame sequence counter width

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
in_valid  in  1  time word present this cycle
in_ch  in  CH_W  channel index of in_data
in_data  in  DATA_W  time word
in_group_end  in  1  closes the current group; may coincide with in_valid
frame_abort  in  1  discards the working frame
frame_ready  out  1  shadow holds an unacknowledged frame (level)
frame_commit  out  1  one-cycle pulse on each commit
frame_seq  out  SEQ_W  count of committed frames, wraps
cur_group  out  GRP_W  group index currently being filled
rd_en  in  1  read request
rd_group  in  GRP_W  read group address
rd_ch  in  CH_W  read channel address
rd_data  out  DATA_W  shadow entry, registered
rd_entry_vld  out  1  valid bit of the entry read
rd_ack  in  1  releases the shadow frame (clears frame_ready)
dup_err  out  1  pulse: write hit an entry already valid in the current group
drop_err  out  1  pulse: in_ch >= NUM_CH, word ignored
ovf_err  out  1  pulse: commit while frame_ready was still set

Behaviour:
- Async reset: all outputs, the working buffer, the shadow buffer, valid bits, cur_group, frame_seq and frame_ready = 0.
- Write: in_valid && in_ch < NUM_CH → working[cur_group][in_ch] <= in_data and its valid bit <= 1 at the next edge. If the valid bit was already set, the new word still overwrites the entry and dup_err pulses for one cycle. If in_ch >= NUM_CH, the word is ignored and drop_err pulses.
- Group advance: in_group_end && cur_group < NUM_GROUPS-1 → cur_group+1. A word in the same cycle is written to the old group.
- Commit: in_group_end && cur_group == NUM_GROUPS-1. At that edge:
  - shadow <= working, with the same-cycle word merged in;
  - working valid bits are cleared and cur_group <= 0;
  - frame_seq increments, wrapping at 2**SEQ_W;
  - frame_commit and frame_ready assert in the following cycle;
  - no input cycle is lost.
- Overflow: commit while frame_ready=1 → shadow is overwritten anyway, ovf_err pulses, frame_ready stays 1.
- frame_ready clears on rd_ack. If rd_ack coincides with a commit, the commit wins and frame_ready stays 1; no ovf_err is raised.
- Read: rd_en → rd_data and rd_entry_vld update 1 cycle later from the shadow. Out-of-range addresses return 0/0. Outputs hold between reads. The shadow changes only at commit.
- Abort: frame_abort → working valid bits cleared, cur_group <= 0; shadow, frame_ready and frame_seq untouched. Abort wins over a same-cycle write, group_end or commit, and suppresses their error pulses.
- Invalid entries in the shadow read as rd_data=0, rd_entry_vld=0.
- Reset asserted mid-frame clears everything immediately, with no clock required.
- Error pulses are single-cycle and mutually independent.

Test Plan:
- NUM_GROUPS=5, NUM_CH=8. Groups 0..4 each receive ch0..7 with data = 16*g+ch, group_end on the last word of each group → one frame_commit, frame_ready=1, frame_seq=1. Reading (3,5) one cycle later gives rd_data=0x35, rd_entry_vld=1.
- Group 0 gets ch2=0x123 then ch2=0x456 → dup_err on the 2nd write. After commit, reading (0,2) returns 0x456; reading (0,3) returns 0 with vld=0.
- NUM_CH=6: in_ch=7 → drop_err=1, no entry set. cur_group is unchanged.
- Commit two frames without rd_ack → ovf_err on the 2nd commit, frame_seq=2, shadow holds frame 2. Then rd_ack → frame_ready=0.
- Fill groups 0..2, assert frame_abort together with in_valid → cur_group=0, no entry written, frame_ready and shadow unchanged. A following full frame commits normally.
- Assert resetn=0 mid-group, asynchronously between clock edges → outputs 0 immediately; after release, the first commit gives frame_seq=1.
